// File: rtl/dma_ahb2apb_bridge.sv
// AHB-lite slave to APB master bridge in front of the DMA register file.
// Each accepted AHB beat becomes one APB transfer, with phases paced by pclken.
module dma_ahb2apb_bridge #(
  parameter int ADDR_BITS     = 24,
  parameter int APB_ADDR_BITS = 13,
  parameter int DATA_BITS     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pclken,
  input  logic                     HSEL,
  input  logic [ADDR_BITS-1:0]     HADDR,
  input  logic [2:0]               HBURST,
  input  logic [1:0]               HSIZE,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [DATA_BITS-1:0]     HWDATA,
  output logic [DATA_BITS-1:0]     HRDATA,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [APB_ADDR_BITS-1:0] paddr,
  output logic [DATA_BITS-1:0]     pwdata,
  input  logic [DATA_BITS-1:0]     prdata,
  input  logic                     pslverr,
  input  logic                     pready
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LATCH, ST_SETUP, ST_ACCESS, ST_RESP, ST_ERR1, ST_ERR2
  } state_t;

  state_t                   state_q;
  logic [APB_ADDR_BITS-1:0] addr_q;
  logic                     write_q;
  logic [APB_ADDR_BITS-1:0] paddr_q;
  logic [DATA_BITS-1:0]     pwdata_q;
  logic [DATA_BITS-1:0]     hrdata_q;
  logic                     psel_q;
  logic                     penable_q;
  logic                     pwrite_q;
  logic                     hready_q;
  logic                     hresp_q;

  logic beat_valid;
  logic beat_legal;
  logic unused_burst;

  // Bursts are split into independent beats, so HBURST carries no information here.
  assign unused_burst = ^HBURST;

  assign beat_valid = HSEL && HTRANS[1];
  assign beat_legal = (HSIZE == 2'b10) && (HADDR[1:0] == 2'b00) &&
                      (HADDR[ADDR_BITS-1:APB_ADDR_BITS] == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
    end else begin
      case (state_q)
        // HREADY is high in these states, so the AHB address phase is sampled here.
        ST_IDLE, ST_RESP, ST_ERR2: begin
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (beat_valid) begin
            hready_q <= 1'b0;
            if (beat_legal) begin
              state_q <= ST_LATCH;
              addr_q  <= HADDR[APB_ADDR_BITS-1:0];
              write_q <= HWRITE;
            end else begin
              state_q <= ST_ERR1;
              hresp_q <= 1'b1;
            end
          end
        end
        ST_LATCH: begin
          pwdata_q <= HWDATA;
          if (pclken) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= addr_q;
            pwrite_q  <= write_q;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (pclken) begin
            penable_q <= 1'b1;
            state_q   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (pclken && pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (!write_q) begin
              hrdata_q <= prdata;
            end
            if (pslverr) begin
              state_q <= ST_ERR1;
              hresp_q <= 1'b1;
            end else begin
              state_q  <= ST_RESP;
              hready_q <= 1'b1;
            end
          end
        end
        ST_ERR1: begin
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
          state_q  <= ST_ERR2;
        end
        default: begin
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign HRDATA  = hrdata_q;
  assign HREADY  = hready_q;
  assign HRESP   = hresp_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_dma_ahb2apb_bridge.sv
// Self-checking bench for dma_ahb2apb_bridge: table-driven single beats with a
// scoreboard queue, plus hand-written back-to-back, stall and reset sequences.
module tb_dma_ahb2apb_bridge;
  localparam int BOUND = 60;

  logic        clk, reset, pclken;
  logic        HSEL, HWRITE, HREADY, HRESP;
  logic [23:0] HADDR;
  logic [2:0]  HBURST;
  logic [1:0]  HSIZE, HTRANS;
  logic [31:0] HWDATA, HRDATA, pwdata, prdata;
  logic [12:0] paddr;
  logic        psel, penable, pwrite, pslverr, pready;

  logic pclken_div   = 1'b0;
  int   stall_target = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int          psel_rise = 0, psel_cyc = 0, pen_cyc = 0, apb_done = 0, stall_cnt = 0;
  logic        psel_prev = 1'b0;
  logic [12:0] last_paddr = '0;
  logic [31:0] last_pwdata = '0;
  logic        last_pwrite = 1'b0;
  logic [31:0] hrd_model = '0;

  typedef struct packed {
    logic [23:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [1:0]  trans;
    logic [31:0] prd;
    logic        slverr;
    logic        exp_resp;
    logic [3:0]  exp_waits;
  } vec_t;

  typedef struct packed {
    logic        resp;
    logic [3:0]  waits;
    logic [31:0] hrdata;
    logic        apb;
    logic [12:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  dma_ahb2apb_bridge dut (
    .clk(clk), .reset(reset), .pclken(pclken),
    .HSEL(HSEL), .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pslverr(pslverr), .pready(pready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // pclken is updated 2 time units after each rising edge.
  initial begin
    pclken = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      pclken = pclken_div ? ~pclken : 1'b1;
    end
  end

  // APB slave (pready stalls) followed by a passive monitor, both on the falling edge.
  initial begin
    pready = 1'b1;
    forever begin
      @(negedge clk);
      if (psel && penable && pclken) begin
        pready = (stall_cnt >= stall_target);
        stall_cnt++;
      end else begin
        pready = 1'b1;
        if (!psel) stall_cnt = 0;
      end
      if (psel) psel_cyc++;
      if (penable) pen_cyc++;
      if (psel && !psel_prev) psel_rise++;
      psel_prev = psel;
      if (psel && penable && pclken && pready) begin
        apb_done++;
        last_paddr  = paddr;
        last_pwdata = pwdata;
        last_pwrite = pwrite;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic [23:0] a, input logic wr, input logic [31:0] wd,
                              input logic [1:0] sz, input logic [1:0] tr, input logic [31:0] prd,
                              input logic se, input logic er, input logic [3:0] w);
    vec_t v;
    v.addr = a; v.wr = wr; v.wdata = wd; v.size = sz; v.trans = tr;
    v.prd = prd; v.slverr = se; v.exp_resp = er; v.exp_waits = w;
    return v;
  endfunction

  task automatic wait_ready(output int waits, output logic resp_or);
    waits = 0;
    resp_or = 1'b0;
    while (HREADY !== 1'b1 && waits < BOUND) begin
      resp_or = resp_or | HRESP;
      waits++;
      @(posedge clk);
      #1;
    end
    chk("hready_bound", 32'(HREADY), 32'd1);
  endtask

  task automatic do_beat(input int idx, input vec_t v);
    exp_t e;
    int   waits, d0, r0, pc0, pe0;
    logic resp_or, legal;
    prdata  = v.prd;
    pslverr = v.slverr;
    d0 = apb_done; r0 = psel_rise; pc0 = psel_cyc; pe0 = pen_cyc;
    legal = v.trans[1] && (v.size == 2'b10) && (v.addr[1:0] == 2'b00) && (v.addr[23:13] == 11'd0);
    if (legal && !v.wr) hrd_model = v.prd;
    e.resp = v.exp_resp; e.waits = v.exp_waits; e.hrdata = hrd_model; e.apb = legal;
    e.paddr = v.addr[12:0]; e.pwdata = v.wdata; e.pwrite = v.wr;
    sb_q.push_back(e);
    HSEL = 1'b1; HADDR = v.addr; HWRITE = v.wr; HSIZE = v.size; HTRANS = v.trans; HBURST = 3'b001;
    @(posedge clk);
    #1;
    HWDATA = v.wdata; HSEL = 1'b0; HTRANS = 2'b00;
    wait_ready(waits, resp_or);
    e = sb_q.pop_front();
    chk("waits", 32'(waits), 32'(e.waits));
    chk("hresp", 32'(HRESP), 32'(e.resp));
    chk("hresp_in_wait", 32'(resp_or), 32'(e.resp));
    chk("hrdata", HRDATA, e.hrdata);
    chk("apb_count", 32'(apb_done - d0), 32'(e.apb));
    chk("psel_rise", 32'(psel_rise - r0), 32'(e.apb));
    chk("psel_cycles", 32'(psel_cyc - pc0), e.apb ? 32'd2 : 32'd0);
    chk("penable_cycles", 32'(pen_cyc - pe0), e.apb ? 32'd1 : 32'd0);
    if (e.apb) begin
      chk("paddr", 32'(last_paddr), 32'(e.paddr));
      chk("pwrite", 32'(last_pwrite), 32'(e.pwrite));
      if (e.pwrite) chk("pwdata", last_pwdata, e.pwdata);
    end
    $display("beat %0d addr=0x%06h wr=%0b size=%0d trans=%0d waits=%0d hresp=%0b hrdata=0x%08h",
             idx, v.addr, v.wr, v.size, v.trans, waits, HRESP, HRDATA);
    @(posedge clk);
    #1;
    chk("hresp_after", 32'(HRESP), 32'd0);
    chk("hready_after", 32'(HREADY), 32'd1);
  endtask

  initial begin
    int   waits, d0, r0, pc0, pe0, n;
    logic resp_or, pk;

    vecs[0]  = mk(24'h000020, 1'b1, 32'h1,        2'b10, 2'b10, 32'h0,        1'b0, 1'b0, 4'd3);
    vecs[1]  = mk(24'h000020, 1'b0, 32'h0,        2'b10, 2'b10, 32'h1,        1'b0, 1'b0, 4'd3);
    vecs[2]  = mk(24'h00002c, 1'b1, 32'h4,        2'b10, 2'b10, 32'h0,        1'b1, 1'b1, 4'd4);
    vecs[3]  = mk(24'h000030, 1'b1, 32'h5,        2'b00, 2'b10, 32'h0,        1'b0, 1'b1, 4'd1);
    vecs[4]  = mk(24'h000022, 1'b1, 32'h6,        2'b10, 2'b10, 32'h0,        1'b0, 1'b1, 4'd1);
    vecs[5]  = mk(24'h002000, 1'b1, 32'h7,        2'b10, 2'b10, 32'h0,        1'b0, 1'b1, 4'd1);
    vecs[6]  = mk(24'h000040, 1'b1, 32'h8,        2'b10, 2'b01, 32'h0,        1'b0, 1'b0, 4'd0);
    vecs[7]  = mk(24'h001ffc, 1'b0, 32'h0,        2'b10, 2'b10, 32'hdeadbeef, 1'b0, 1'b0, 4'd3);
    vecs[8]  = mk(24'h000010, 1'b1, 32'ha5a5c3c3, 2'b10, 2'b11, 32'h0,        1'b0, 1'b0, 4'd3);
    vecs[9]  = mk(24'h800000, 1'b0, 32'h0,        2'b10, 2'b10, 32'h55,       1'b0, 1'b1, 4'd1);
    vecs[10] = mk(24'h000008, 1'b0, 32'h0,        2'b01, 2'b10, 32'h66,       1'b0, 1'b1, 4'd1);
    vecs[11] = mk(24'h000004, 1'b0, 32'h0,        2'b10, 2'b11, 32'h12345678, 1'b0, 1'b0, 4'd3);

    reset = 1'b0; HSEL = 1'b0; HADDR = '0; HBURST = '0; HSIZE = 2'b10; HTRANS = 2'b00;
    HWRITE = 1'b0; HWDATA = '0; prdata = '0; pslverr = 1'b0;
    #12;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) do_beat(i, vecs[i]);

    // Read 0x20 immediately followed by a SEQ write to 0x24 with no IDLE gap.
    prdata = 32'h1; pslverr = 1'b0;
    d0 = apb_done; r0 = psel_rise;
    HSEL = 1'b1; HADDR = 24'h20; HWRITE = 1'b0; HSIZE = 2'b10; HTRANS = 2'b10;
    @(posedge clk);
    #1;
    HADDR = 24'h24; HWRITE = 1'b1; HTRANS = 2'b11;
    wait_ready(waits, resp_or);
    chk("b2b_rd_waits", 32'(waits), 32'd3);
    chk("b2b_rd_hrdata", HRDATA, 32'h1);
    chk("b2b_rd_pwrite", 32'(last_pwrite), 32'd0);
    $display("b2b read addr=0x000020 waits=%0d hrdata=0x%08h", waits, HRDATA);
    @(posedge clk);
    #1;
    HWDATA = 32'h2; HSEL = 1'b0; HTRANS = 2'b00;
    chk("b2b_accept_hready", 32'(HREADY), 32'd0);
    wait_ready(waits, resp_or);
    chk("b2b_wr_waits", 32'(waits), 32'd3);
    chk("b2b_wr_hresp", 32'(HRESP), 32'd0);
    chk("b2b_wr_paddr", 32'(last_paddr), 32'h24);
    chk("b2b_wr_pwdata", last_pwdata, 32'h2);
    chk("b2b_wr_pwrite", 32'(last_pwrite), 32'd1);
    chk("b2b_apb_count", 32'(apb_done - d0), 32'd2);
    chk("b2b_psel_rises", 32'(psel_rise - r0), 32'd2);
    chk("b2b_hrdata_kept", HRDATA, 32'h1);
    $display("b2b write addr=0x000024 waits=%0d hresp=%0b", waits, HRESP);
    @(posedge clk);
    #1;
    hrd_model = 32'h1;

    // pclken every second cycle, pready low for two strobes.
    pclken_div = 1'b1; stall_target = 2; pslverr = 1'b0;
    @(posedge clk);
    #1;
    d0 = apb_done; r0 = psel_rise; pc0 = psel_cyc; pe0 = pen_cyc;
    HSEL = 1'b1; HADDR = 24'h28; HWRITE = 1'b1; HSIZE = 2'b10; HTRANS = 2'b10;
    @(posedge clk);
    #1;
    HWDATA = 32'h3; HSEL = 1'b0; HTRANS = 2'b00;
    #2;
    pk = pclken;
    wait_ready(waits, resp_or);
    chk("stall_waits", 32'(waits), pk ? 32'd9 : 32'd10);
    chk("stall_hresp", 32'(HRESP), 32'd0);
    chk("stall_apb_count", 32'(apb_done - d0), 32'd1);
    chk("stall_psel_rise", 32'(psel_rise - r0), 32'd1);
    chk("stall_psel_cycles", 32'(psel_cyc - pc0), 32'd8);
    chk("stall_penable_cycles", 32'(pen_cyc - pe0), 32'd6);
    chk("stall_paddr", 32'(last_paddr), 32'h28);
    chk("stall_pwdata", last_pwdata, 32'h3);
    chk("stall_pwrite", 32'(last_pwrite), 32'd1);
    $display("stall write addr=0x000028 waits=%0d hresp=%0b", waits, HRESP);
    pclken_div = 1'b0; stall_target = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    // Reset asserted while the transfer sits in ACCESS.
    stall_target = 1000;
    d0 = apb_done;
    HSEL = 1'b1; HADDR = 24'h30; HWRITE = 1'b1; HSIZE = 2'b10; HTRANS = 2'b10;
    @(posedge clk);
    #1;
    HWDATA = 32'h5; HSEL = 1'b0; HTRANS = 2'b00;
    n = 0;
    while (!(psel && penable) && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("rst6_in_access", 32'(penable), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst6_psel", 32'(psel), 32'd0);
    chk("rst6_penable", 32'(penable), 32'd0);
    chk("rst6_hready", 32'(HREADY), 32'd1);
    chk("rst6_hresp", 32'(HRESP), 32'd0);
    chk("rst6_hrdata", HRDATA, 32'd0);
    hrd_model = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b1; stall_target = 0;
    @(posedge clk);
    #1;
    chk("rst6_dropped", 32'(apb_done - d0), 32'd0);
    $display("reset during access: psel=%0b penable=%0b hready=%0b", psel, penable, HREADY);
    do_beat(12, mk(24'h000034, 1'b1, 32'h6, 2'b10, 2'b10, 32'h0, 1'b0, 1'b0, 4'd3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
